systolic_tile_sequencer: RTL and testbench
==========================================

// Module: systolic_tile_sequencer
// PURPOSE
// Sequences one SIZE x SIZE output tile through the systolic array over K-tiles.
// Per K-tile: handshakes operands from the skew feeder, starts the array, steps the feeder and captures results.
// The array clears its accumulators whenever it returns to IDLE, so K-tile partial sums are accumulated here.
// Final 32-bit rows stream out over a valid/ready port. Sits between the command queue, operand feeder and systolic_array.
// PARAMETERS
// SIZE     8   array dimension; must match systolic_array
// ACC_W    32  partial-sum / output element width
// WDOG     3*SIZE+4  max cycles from sa_start to sa_done before timeout
// PORTS
// clock         in   1             clock
// reset         in   1             synchronous, active-high
// cmd_valid     in   1             new output-tile command
// cmd_ready     out  1             high only in S_IDLE
// cmd_ktiles    in   8             number of K-tiles to accumulate (0 = illegal)
// tile_valid    in   1             feeder holds next K-tile operands
// tile_ready    out  1             one-cycle accept pulse (S_TILE_WAIT)
// feed_en       out  1             feeder must drive step feed_step onto weight_in/input_in
// feed_step     out  8             skew step index 0..3*SIZE-3
// sa_start      out  1             systolic_array start (level)
// sa_accumulate out  1             tied 0
// sa_done       in   1             systolic_array done
// sa_result     in   SIZExSIZEx20  systolic_array result, signed
// out_valid     out  1             output row valid
// out_ready     in   1             consumer accepts row
// out_row       out  SIZExACC_W    signed final row
// out_row_idx   out  8             row index 0..SIZE-1
// out_last      out  1             high with row SIZE-1
// busy          out  1             state != S_IDLE
// err_cmd       out  1             1-cycle pulse: cmd accepted with cmd_ktiles==0; no tile run, no output
// err_timeout   out  1             sticky until next accepted cmd: watchdog expired
// BEHAVIOUR
// Reset: state S_IDLE. All outputs 0 except cmd_ready=1. Counters 0. psum contents don't-care.
// Reset mid-operation aborts immediately. sa_start drops, so the array returns to IDLE.
// S_IDLE: cmd_valid&cmd_ready -> latch ktiles, clear tile_cnt and err_timeout -> S_TILE_WAIT. ktiles==0 -> err_cmd, stay S_IDLE.
// S_TILE_WAIT: tile_valid -> tile_ready=1 this cycle -> S_START.
// S_START: sa_start=1 (array IDLE->LOADING). -> S_RUN. feed_step=0.
// S_RUN: sa_start held 1. First S_RUN cycle = array LOADING, feed_en=0.
//   From the next cycle (array COMPUTING), feed_en=1 for exactly 3*SIZE-2 cycles; feed_step increments 0..3*SIZE-3.
//   sa_done -> S_CAPTURE. Watchdog counts from S_START; reaching WDOG without sa_done -> err_timeout=1, sa_start=0, S_IDLE.
// S_CAPTURE: sa_start stays 1 (array held in DONE, results stable). SIZE cycles, row r=0..SIZE-1:
//   psum[r][c] = (tile_cnt==0) ? sext(sa_result[r][c]) : psum[r][c] + sext(sa_result[r][c]).
//   Two's-complement wrap, no saturation. Then tile_cnt++ -> S_RELEASE.
// S_RELEASE: sa_start=0 one cycle (array DONE->IDLE, clears). tile_cnt==ktiles -> S_OUT, else S_TILE_WAIT.
// S_OUT: out_valid=1. out_row=psum[out_row_idx]. Row advances only on out_valid&out_ready.
//   out_row/out_row_idx stable while stalled. Accept with out_last -> S_IDLE.
// cmd_valid outside S_IDLE is ignored (cmd_ready=0). tile_valid outside S_TILE_WAIT is ignored.
// Latency, ktiles=N, no stalls: per tile 1(wait)+1+ (3*SIZE)+SIZE+1 cycles; first out_valid one cycle after the last S_RELEASE.
// Worst-case magnitude: 255 tiles * SIZE*2^14 fits in ACC_W=32 for SIZE<=16.
// STRUCTURE
// Package npu_seq_pkg: seq_state_t {S_IDLE,S_TILE_WAIT,S_START,S_RUN,S_CAPTURE,S_RELEASE,S_OUT}, RES_W=20, ACC_W=32, STEP_W=8.
// Sub-module psum_bank: SIZE x SIZE x ACC_W register bank with row write (load/add select) and row read.
//   Ports: row_sel, wr_en, load, din[SIZE] 20b, dout[SIZE].
// Top: FSM, tile/step/watchdog/row counters, handshake logic.
// TESTING
// SIZE=4, ktiles=1, A=B=identity*1 -> out rows = identity (1 on diagonal), out_last on row 3, 4 accepts.
// ktiles=3, all operands 1 -> every out_row element = 3*SIZE=12; sa_start low exactly 1 cycle between tiles.
// ktiles=2, result -5 then +2 per element -> -3 (sign extension); 20b max 524287 x2 -> 1048574 (no 20b overflow).
// out_ready held low 10 cycles on row 1 -> out_row/out_row_idx stable, no row skipped or duplicated.
// cmd_ktiles=0 -> err_cmd pulse 1 cycle, no tile_ready, no out_valid; sa_done stubbed never -> err_timeout after WDOG cycles, S_IDLE.
// reset asserted during S_RUN of tile 2 -> next cycle sa_start=0, cmd_ready=1; a new cmd runs cleanly with psum overwritten.

Source files
------------

// File: rtl/npu_seq_pkg.sv
// Shared types and widths for the systolic tile sequencer.
package npu_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_TILE_WAIT,
    S_START,
    S_RUN,
    S_CAPTURE,
    S_RELEASE,
    S_OUT
  } seq_state_t;

  // Width of one signed systolic_array result element.
  localparam int RES_W  = 20;
  // Width of one accumulated / output element.
  localparam int ACC_W  = 32;
  // Width of the skew step index and the row index outputs.
  localparam int STEP_W = 8;

  // Sign-extend one array result element to the accumulator width.
  function automatic logic [ACC_W-1:0] sext_res(input logic [RES_W-1:0] v);
    return {{(ACC_W-RES_W){v[RES_W-1]}}, v};
  endfunction

endpackage

// File: rtl/psum_bank.sv
// SIZE x SIZE bank of ACC_W partial sums. One row is written per cycle,
// either loaded from the sign-extended array result or added to it, and
// the same selected row is always presented on dout.
module psum_bank
  import npu_seq_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                       clock,
  input  logic [ROW_W-1:0]           row_sel,
  input  logic                       wr_en,
  input  logic                       load,
  input  logic [SIZE-1:0][RES_W-1:0] din,
  output logic [SIZE-1:0][ACC_W-1:0] dout
);

  logic [SIZE-1:0][ACC_W-1:0] mem [SIZE];

  // Row write: load on the first K-tile, two's-complement add afterwards.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int c = 0; c < SIZE; c++) begin
        if (load) begin
          mem[row_sel][c] <= sext_res(din[c]);
        end else begin
          mem[row_sel][c] <= mem[row_sel][c] + sext_res(din[c]);
        end
      end
    end
  end

  // Combinational read of the selected row.
  always_comb begin
    dout = mem[row_sel];
  end

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Sequences one SIZE x SIZE output tile through the systolic array over a
// number of K-tiles, accumulating partial sums locally because the array
// clears itself each time it returns to IDLE, then streams the final rows.
//
// Handshakes: cmd, tile and out ports all transfer on a cycle where both
// valid and ready are high at the rising clock edge. cmd_ready is high only
// in S_IDLE; tile_ready is a one-cycle pulse in S_TILE_WAIT when tile_valid
// is seen; out_valid holds with out_row/out_row_idx stable until out_ready.
module systolic_tile_sequencer
  import npu_seq_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int WDOG = 3*SIZE+4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [7:0]                       cmd_ktiles,
  input  logic                             tile_valid,
  output logic                             tile_ready,
  output logic                             feed_en,
  output logic [STEP_W-1:0]                feed_step,
  output logic                             sa_start,
  output logic                             sa_accumulate,
  input  logic                             sa_done,
  input  logic [SIZE-1:0][SIZE-1:0][RES_W-1:0] sa_result,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SIZE-1:0][ACC_W-1:0]       out_row,
  output logic [STEP_W-1:0]                out_row_idx,
  output logic                             out_last,
  output logic                             busy,
  output logic                             err_cmd,
  output logic                             err_timeout,
  output seq_state_t                       dbg_state
);

  localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  // Last watchdog count at which the run is still allowed to finish.
  localparam logic [15:0] WD_LIMIT  = 16'(WDOG - 1);
  // feed_en spans watchdog counts 2 .. 3*SIZE-1 (3*SIZE-2 cycles).
  localparam logic [15:0] FEED_LAST = 16'(3*SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SIZE - 1);

  seq_state_t state;
  seq_state_t state_next;

  logic [7:0]       ktiles_q;
  logic [7:0]       tile_cnt;
  logic [15:0]      wd_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             row_last;
  logic             cmd_fire;
  logic             timeout_hit;
  logic             bank_wr;
  logic [SIZE-1:0][ACC_W-1:0] bank_row;

  assign row_last    = (row_cnt == ROW_MAX);
  assign cmd_fire    = (state == S_IDLE) && cmd_valid;
  // wd_cnt is 0 in S_START and k on the k-th S_RUN cycle, so the run is
  // abandoned on its WDOG-th cycle counted from S_START.
  assign timeout_hit = (state == S_RUN) && !sa_done && (wd_cnt >= WD_LIMIT);

  // State register; reset aborts any run at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/control outputs.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    tile_ready = 1'b0;
    sa_start   = 1'b0;
    out_valid  = 1'b0;
    bank_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && (cmd_ktiles != 8'd0)) begin
          state_next = S_TILE_WAIT;
        end
      end
      S_TILE_WAIT: begin
        if (tile_valid) begin
          tile_ready = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        sa_start   = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        sa_start = 1'b1;
        if (sa_done) begin
          state_next = S_CAPTURE;
        end else if (timeout_hit) begin
          state_next = S_IDLE;
        end
      end
      S_CAPTURE: begin
        // Array stays in DONE so sa_result is stable while rows are taken.
        sa_start = 1'b1;
        bank_wr  = 1'b1;
        if (row_last) begin
          state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // One low cycle on sa_start returns the array to IDLE and clears it.
        if (tile_cnt == ktiles_q) begin
          state_next = S_OUT;
        end else begin
          state_next = S_TILE_WAIT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready && row_last) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Command latch, tile/watchdog/row counters and error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      ktiles_q    <= 8'd0;
      tile_cnt    <= 8'd0;
      wd_cnt      <= 16'd0;
      row_cnt     <= '0;
      err_cmd     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_cmd <= cmd_fire && (cmd_ktiles == 8'd0);
      if (cmd_fire) begin
        ktiles_q    <= cmd_ktiles;
        tile_cnt    <= 8'd0;
        err_timeout <= 1'b0;
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
      if ((state == S_START) || (state == S_RUN)) begin
        wd_cnt <= wd_cnt + 16'd1;
      end else begin
        wd_cnt <= 16'd0;
      end
      case (state)
        S_RUN: begin
          row_cnt <= '0;
        end
        S_CAPTURE: begin
          if (row_last) begin
            row_cnt  <= '0;
            tile_cnt <= tile_cnt + 8'd1;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          row_cnt <= '0;
        end
        S_OUT: begin
          if (out_ready) begin
            row_cnt <= row_last ? '0 : row_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  psum_bank #(
    .SIZE  (SIZE),
    .ROW_W (ROW_W)
  ) u_psum_bank (
    .clock   (clock),
    .row_sel (row_cnt),
    .wr_en   (bank_wr),
    .load    (tile_cnt == 8'd0),
    .din     (sa_result[row_cnt]),
    .dout    (bank_row)
  );

  // Feeder stepping: wd_cnt==1 is the array LOADING cycle, steps follow.
  assign feed_en       = (state == S_RUN) && (wd_cnt >= 16'd2) && (wd_cnt <= FEED_LAST);
  assign feed_step     = feed_en ? STEP_W'(wd_cnt - 16'd2) : '0;
  assign sa_accumulate = 1'b0;

  // Output row port; held at zero outside S_OUT.
  assign out_row     = out_valid ? bank_row : '0;
  assign out_row_idx = out_valid ? STEP_W'(row_cnt) : '0;
  assign out_last    = out_valid && row_last;

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer at SIZE=4 with a behavioural array stub.
module tb_systolic_tile_sequencer;
  import npu_seq_pkg::*;

  localparam int SIZE = 4;
  localparam int WDOG = 3*SIZE+4;
  localparam int W    = 1 + STEP_W + SIZE*ACC_W;

  typedef logic [SIZE-1:0][SIZE-1:0][RES_W-1:0] mat_t;
  typedef logic [SIZE-1:0][ACC_W-1:0] row_t;

  logic clock = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready, tile_valid, tile_ready, feed_en;
  logic [7:0] cmd_ktiles;
  logic [STEP_W-1:0] feed_step, out_row_idx;
  logic sa_start, sa_accumulate, out_valid, out_ready, out_last, busy;
  logic err_cmd, err_timeout;
  logic sa_done = 1'b0;
  mat_t sa_result = '0;
  row_t out_row;
  seq_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  mat_t res_q[$];
  row_t exp_rows[SIZE];
  logic done_en = 1'b1;
  int stub_cnt = 0;
  int feed_idx = 0;
  int start_rises = 0;
  int tile_ready_seen = 0;
  int out_valid_seen = 0;

  systolic_tile_sequencer #(.SIZE(SIZE), .WDOG(WDOG)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ktiles(cmd_ktiles),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .feed_en(feed_en), .feed_step(feed_step),
    .sa_start(sa_start), .sa_accumulate(sa_accumulate),
    .sa_done(sa_done), .sa_result(sa_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last),
    .busy(busy), .err_cmd(err_cmd), .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  // Clock and hard time limit.
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic mat_t mat_fill(input int v);
    mat_t m;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        m[r][c] = RES_W'(v);
    return m;
  endfunction

  task automatic rows_fill(input int v);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        exp_rows[r][c] = ACC_W'(v);
  endtask

  task automatic push_exp();
    for (int r = 0; r < SIZE; r++)
      exp_q.push_back({(r == SIZE-1), STEP_W'(r), exp_rows[r]});
  endtask

  // Driver: present a command until cmd_ready, bounded.
  task automatic send_cmd(input logic [7:0] k);
    bit got = 1'b0;
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_ktiles = k;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cmd_ktiles = 8'd0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd_ready never seen, actual=0 required=1");
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL %s: busy after %0d cycles, actual=1 required=0", name, budget);
    end
  endtask

  task automatic wait_out_valid(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!out_valid && n < budget);
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL %s: no out_valid within %0d cycles", name, budget);
    end
  endtask

  // Array stub: pops one result matrix per start, raises sa_done on the
  // 3*SIZE-th run cycle, and checks the feeder step sequence.
  always @(negedge clock) begin
    if (reset || !sa_start) begin
      stub_cnt = 0;
      sa_done = 1'b0;
    end else begin
      stub_cnt++;
      if (stub_cnt == 1) begin
        start_rises++;
        feed_idx = 0;
        sa_result = (res_q.size() != 0) ? res_q.pop_front() : '0;
      end
      if (feed_en) begin
        check("feed_step", 64'(feed_step), 64'(feed_idx));
        feed_idx++;
      end
      if (done_en && stub_cnt == 3*SIZE+1)
        check("feed_count", 64'(feed_idx), 64'(3*SIZE-2));
      sa_done = done_en && (stub_cnt > 3*SIZE);
    end
  end

  // Scoreboard monitor: every accepted output row is popped and compared.
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (!reset) begin
      if (tile_ready) tile_ready_seen++;
      if (out_valid) out_valid_seen++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: row idx=%0d accepted with nothing expected", out_row_idx);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_row_idx, out_row} !== e) begin
            errors++;
            $display("FAIL sb_row: actual last=%0b idx=%0d row=%h required last=%0b idx=%0d row=%h",
                     out_last, out_row_idx, out_row, e[W-1], e[W-2 -: STEP_W], e[SIZE*ACC_W-1:0]);
          end
        end
      end
    end
  end

  initial begin
    int base, n, cnt;
    mat_t m0, m1;
    row_t snap;

    reset = 1'b1; cmd_valid = 1'b0; cmd_ktiles = 8'd0;
    tile_valid = 1'b0; out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sa_start", 64'(sa_start), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_tile_ready", 64'(tile_ready), 64'd0);
    check("rst_feed_en", 64'(feed_en), 64'd0);
    check("rst_errs", 64'({err_cmd, err_timeout}), 64'd0);
    check("rst_out_row", 64'(out_row == '0), 64'd1);
    check("rst_sa_accumulate", 64'(sa_accumulate), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    @(posedge clock); #1;
    reset = 1'b0;
    tile_valid = 1'b1;

    // ktiles=1 identity result; latency to first out_valid.
    m0 = '0;
    for (int i = 0; i < SIZE; i++) m0[i][i] = RES_W'(1);
    res_q.push_back(m0);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        exp_rows[r][c] = (r == c) ? 32'd1 : 32'd0;
    push_exp();
    base = start_rises;
    send_cmd(8'd1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!out_valid && n < 100);
    check("first_out_latency", 64'(n), 64'd20);
    wait_idle("ident_idle", 100);
    check("ident_starts", 64'(start_rises - base), 64'd1);
    check("ident_drained", 64'(exp_q.size()), 64'd0);

    // ktiles=3, all-ones operands give SIZE per tile: 12 accumulated.
    for (int t = 0; t < 3; t++) res_q.push_back(mat_fill(SIZE));
    rows_fill(3*SIZE);
    push_exp();
    base = start_rises;
    send_cmd(8'd3);
    wait_idle("ones_idle", 300);
    check("ones_starts", 64'(start_rises - base), 64'd3);
    check("ones_drained", 64'(exp_q.size()), 64'd0);

    // Sign extension: -5 then +2 gives -3.
    res_q.push_back(mat_fill(-5));
    res_q.push_back(mat_fill(2));
    rows_fill(-3);
    push_exp();
    send_cmd(8'd2);
    wait_idle("neg_idle", 200);

    // 20-bit max twice, with the consumer stalling 10+ cycles on row 1.
    res_q.push_back(mat_fill(524287));
    res_q.push_back(mat_fill(524287));
    rows_fill(1048574);
    push_exp();
    out_ready = 1'b0;
    send_cmd(8'd2);
    wait_out_valid("stall_first_valid", 200);
    @(posedge clock); #1 out_ready = 1'b1;
    @(posedge clock); #1 out_ready = 1'b0;
    @(negedge clock);
    snap = out_row;
    check("stall_idx", 64'(out_row_idx), 64'd1);
    repeat (10) begin
      @(negedge clock);
      check("stall_hold_valid", 64'(out_valid), 64'd1);
      check("stall_hold_idx", 64'(out_row_idx), 64'd1);
      check("stall_hold_row", 64'(out_row == snap), 64'd1);
    end
    @(posedge clock); #1 out_ready = 1'b1;
    wait_idle("stall_idle", 100);
    check("stall_drained", 64'(exp_q.size()), 64'd0);

    // Distinct per-element values, feeder initially not ready.
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        m0[r][c] = RES_W'((r*SIZE + c)*3 - 20);
        m1[r][c] = RES_W'(100 - (r*SIZE + c)*7);
        exp_rows[r][c] = ACC_W'(((r*SIZE + c)*3 - 20) + (100 - (r*SIZE + c)*7));
      end
    res_q.push_back(m0);
    res_q.push_back(m1);
    push_exp();
    tile_valid = 1'b0;
    tile_ready_seen = 0;
    send_cmd(8'd2);
    cnt = 0;
    repeat (5) begin
      @(negedge clock);
      if (sa_start || !busy) cnt++;
    end
    check("tile_wait_hold", 64'(cnt), 64'd0);
    check("tile_wait_no_ready", 64'(tile_ready_seen), 64'd0);
    @(posedge clock); #1 tile_valid = 1'b1;
    wait_idle("mixed_idle", 200);
    check("mixed_tile_ready_pulses", 64'(tile_ready_seen), 64'd2);
    check("mixed_drained", 64'(exp_q.size()), 64'd0);

    // ktiles=0: one-cycle err_cmd, nothing else happens.
    tile_ready_seen = 0;
    out_valid_seen = 0;
    send_cmd(8'd0);
    @(negedge clock);
    check("err_cmd_pulse", 64'(err_cmd), 64'd1);
    check("err_cmd_idle", 64'(busy), 64'd0);
    @(negedge clock);
    check("err_cmd_clear", 64'(err_cmd), 64'd0);
    repeat (8) @(negedge clock);
    check("err_cmd_no_tile", 64'(tile_ready_seen), 64'd0);
    check("err_cmd_no_out", 64'(out_valid_seen), 64'd0);

    // Watchdog: array never finishes.
    done_en = 1'b0;
    out_valid_seen = 0;
    send_cmd(8'd1);
    cnt = 0;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
      if (sa_start) cnt++;
    end
    check("wdog_start_cycles", 64'(cnt), 64'(WDOG));
    check("wdog_idle", 64'(busy), 64'd0);
    check("wdog_err", 64'(err_timeout), 64'd1);
    repeat (3) @(negedge clock);
    check("wdog_err_sticky", 64'(err_timeout), 64'd1);
    check("wdog_no_out", 64'(out_valid_seen), 64'd0);
    done_en = 1'b1;

    // Next accepted command clears err_timeout.
    res_q.push_back(mat_fill(9));
    rows_fill(9);
    push_exp();
    send_cmd(8'd1);
    @(negedge clock);
    check("wdog_err_cleared", 64'(err_timeout), 64'd0);
    wait_idle("clear_idle", 100);

    // Reset during the run of tile 2, then a clean command.
    for (int t = 0; t < 3; t++) res_q.push_back(mat_fill(100));
    base = start_rises;
    send_cmd(8'd3);
    n = 0;
    while (!(start_rises == base + 2 && stub_cnt >= 3 && stub_cnt <= 5) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("rst_mid_reached_run", 64'(dbg_state), 64'(S_RUN));
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("rst_mid_sa_start", 64'(sa_start), 64'd0);
    check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
    res_q.delete();
    res_q.push_back(mat_fill(7));
    rows_fill(7);
    push_exp();
    send_cmd(8'd1);
    wait_idle("rst_recover_idle", 100);
    check("rst_recover_drained", 64'(exp_q.size()), 64'd0);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
